// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg
//   Shared types and default widths for the two-master memory bus arbiter.
//   arb_state_t : per-channel arbitration state (idle / locked to an owner)
//   arb_owner_t : master id (data stage = 0, fetch stage = 1)
package riscv_bus_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_DATA, OWN_FETCH} arb_owner_t;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int BE_W       = ARB_DATA_W / 8;

endpackage

// File: rtl/dualport_bus.sv
// dualport_bus
//   Memory port with independent read and write channels.
//   master modport: drives rd/wr request, address, byte enables and write
//   data; receives rd/wr grants and read data (valid one cycle after rd_gnt).
interface dualport_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [BE_W-1:0]   rd_be;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr, rd_be,
    input  rd_gnt, rd_data,
    output wr_req, wr_addr, wr_be, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, rd_be,
    output rd_gnt, rd_data,
    input  wr_req, wr_addr, wr_be, wr_data,
    output wr_gnt
  );
endinterface

// File: rtl/riscv_bus_arb_chan.sv
// riscv_bus_arb_chan
//   One arbitration channel (used for both read and write). Picks a winner
//   among two requesters, muxes the winner's payload to memory, forwards the
//   memory grant, and locks onto the owner while memory stalls.
//   Optional feature macro: RISCV_ARB_RR_EN (round-robin tie break via a
//   'last grantee' bit; otherwise master 0 wins every tie).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req, pay     : per-master request and packed payload (addr/be/data)
//   mem_gnt      : grant from memory
//   mem_req      : request toward memory
//   mem_pay      : selected payload, zero when nothing is driven
//   gnt          : per-master grant (combinational from mem_gnt)
//
//   state    | meaning
//   ARB_IDLE | no lock; winner chosen combinationally each cycle
//   ARB_BUSY | locked to owner_q until memory grants or owner drops req
module riscv_bus_arb_chan
  import riscv_bus_pkg::*;
#(
  parameter int PAY_W = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0][PAY_W-1:0] pay,
  input  logic                  mem_gnt,
  output logic                  mem_req,
  output logic [PAY_W-1:0]      mem_pay,
  output logic [1:0]            gnt
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic       win;
  logic       sel;
  logic       active;

`ifdef RISCV_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the master that was not granted most recently wins.
  always_comb begin
    if (req == 2'b11) win = ~last_q;
    else              win = ~req[0];
  end
`else
  always_comb begin
    win = ~req[0];
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel     = win;
    active  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        sel    = win;
        active = |req;
        if (active && !mem_gnt) begin
          state_d = ARB_BUSY;
          owner_d = arb_owner_t'(win);
        end
      end
      ARB_BUSY: begin
        sel    = logic'(owner_q);
        // Owner dropping its request is a protocol violation: release the lock.
        active = req[sel];
        if (!active || mem_gnt) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    mem_req  = active;
    mem_pay  = active ? pay[sel] : '0;
    gnt      = '0;
    gnt[sel] = active & mem_gnt;
  end

`ifdef RISCV_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (active && mem_gnt) last_d = sel;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_DATA;
`ifdef RISCV_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef RISCV_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
//   Shares one dualport_bus memory port between the data stage (master 0)
//   and the fetch stage (master 1). Read and write channels arbitrate
//   independently; read data is steered back to the master whose read was
//   granted in the previous cycle.
//   Optional feature macro: RISCV_ARB_RR_EN (round-robin tie break).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   mx_rd_req/addr/be, mx_rd_gnt     : read request channel of master x
//   mx_rd_valid, mx_rd_data          : read return (data is 0 when not valid)
//   mx_wr_req/addr/be/data, mx_wr_gnt: write request channel of master x
//   mem_master                       : memory side bus
module riscv_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_rd_req,
  input  logic [ADDR_W-1:0]     m0_rd_addr,
  input  logic [DATA_W/8-1:0]   m0_rd_be,
  output logic                  m0_rd_gnt,
  output logic                  m0_rd_valid,
  output logic [DATA_W-1:0]     m0_rd_data,
  input  logic                  m0_wr_req,
  input  logic [ADDR_W-1:0]     m0_wr_addr,
  input  logic [DATA_W/8-1:0]   m0_wr_be,
  input  logic [DATA_W-1:0]     m0_wr_data,
  output logic                  m0_wr_gnt,

  input  logic                  m1_rd_req,
  input  logic [ADDR_W-1:0]     m1_rd_addr,
  input  logic [DATA_W/8-1:0]   m1_rd_be,
  output logic                  m1_rd_gnt,
  output logic                  m1_rd_valid,
  output logic [DATA_W-1:0]     m1_rd_data,
  input  logic                  m1_wr_req,
  input  logic [ADDR_W-1:0]     m1_wr_addr,
  input  logic [DATA_W/8-1:0]   m1_wr_be,
  input  logic [DATA_W-1:0]     m1_wr_data,
  output logic                  m1_wr_gnt,

  dualport_bus.master           mem_master
);

  localparam int BW       = DATA_W / 8;
  localparam int RD_PAY_W = ADDR_W + BW;
  localparam int WR_PAY_W = ADDR_W + BW + DATA_W;

  logic [1:0][RD_PAY_W-1:0] rd_pay;
  logic [1:0][WR_PAY_W-1:0] wr_pay;
  logic [RD_PAY_W-1:0]      rd_mem_pay;
  logic [WR_PAY_W-1:0]      wr_mem_pay;
  logic [1:0]               rd_gnt;
  logic [1:0]               wr_gnt;

  assign rd_pay[0] = {m0_rd_addr, m0_rd_be};
  assign rd_pay[1] = {m1_rd_addr, m1_rd_be};
  assign wr_pay[0] = {m0_wr_addr, m0_wr_be, m0_wr_data};
  assign wr_pay[1] = {m1_wr_addr, m1_wr_be, m1_wr_data};

  riscv_bus_arb_chan #(.PAY_W(RD_PAY_W)) u_rd_chan (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_rd_req, m0_rd_req}),
    .pay     (rd_pay),
    .mem_gnt (mem_master.rd_gnt),
    .mem_req (mem_master.rd_req),
    .mem_pay (rd_mem_pay),
    .gnt     (rd_gnt)
  );

  riscv_bus_arb_chan #(.PAY_W(WR_PAY_W)) u_wr_chan (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_wr_req, m0_wr_req}),
    .pay     (wr_pay),
    .mem_gnt (mem_master.wr_gnt),
    .mem_req (mem_master.wr_req),
    .mem_pay (wr_mem_pay),
    .gnt     (wr_gnt)
  );

  assign {mem_master.rd_addr, mem_master.rd_be} = rd_mem_pay;
  assign {mem_master.wr_addr, mem_master.wr_be, mem_master.wr_data} = wr_mem_pay;

  assign m0_rd_gnt = rd_gnt[0];
  assign m1_rd_gnt = rd_gnt[1];
  assign m0_wr_gnt = wr_gnt[0];
  assign m1_wr_gnt = wr_gnt[1];

  // Read return: remember who was granted so next cycle's data goes there.
  arb_owner_t ret_owner_q, ret_owner_d;
  logic       ret_pend_q, ret_pend_d;

  always_comb begin
    ret_pend_d  = |rd_gnt;
    ret_owner_d = ret_owner_q;
    if (rd_gnt[1])      ret_owner_d = OWN_FETCH;
    else if (rd_gnt[0]) ret_owner_d = OWN_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_pend_q  <= 1'b0;
      ret_owner_q <= OWN_DATA;
    end else begin
      ret_pend_q  <= ret_pend_d;
      ret_owner_q <= ret_owner_d;
    end
  end

  assign m0_rd_valid = ret_pend_q && (ret_owner_q == OWN_DATA);
  assign m1_rd_valid = ret_pend_q && (ret_owner_q == OWN_FETCH);
  assign m0_rd_data  = m0_rd_valid ? mem_master.rd_data : '0;
  assign m1_rd_data  = m1_rd_valid ? mem_master.rd_data : '0;

endmodule

// File: doc/riscv_bus_arbiter.md
# riscv_bus_arbiter

Two-master arbiter that shares one `dualport_bus` memory port between the data-memory stage (master 0) and the instruction-fetch stage (master 1). Read and write channels are arbitrated independently. Each channel locks its owner until the memory grants the request. Read data is routed back to the master that issued the request. The block sits between the pipeline's memory/fetch stages and the memory `dualport_bus.master` connection.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`

Ports (`x` = 0 for the data master, `x` = 1 for the fetch master):
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `mx_rd_req`  in  1  read request; held until `mx_rd_gnt`
- `mx_rd_addr`  in  ADDR_W  word-aligned read address
- `mx_rd_be`  in  DATA_W/8  read byte enables
- `mx_rd_gnt`  out  1  one-cycle read grant
- `mx_rd_valid`  out  1  one-cycle pulse; `mx_rd_data` is valid in that cycle
- `mx_rd_data`  out  DATA_W  returned read data; 0 when `mx_rd_valid` is low
- `mx_wr_req`  in  1  write request; held until `mx_wr_gnt`
- `mx_wr_addr`  in  ADDR_W  write address
- `mx_wr_be`  in  DATA_W/8  write byte enables
- `mx_wr_data`  in  DATA_W  write data
- `mx_wr_gnt`  out  1  one-cycle write grant
- `mem_master`  —  —  `dualport_bus.master` modport toward memory

## Operation
- Each channel (rd, wr) runs an independent FSM with states `IDLE` and `BUSY`, plus an `owner` register.
- In `IDLE`:
  - The winner among asserted requests is chosen combinationally.
  - The winner's req/addr/be/data are driven onto `mem_master` in the same cycle.
  - If the memory grant is high in that cycle, the grant is forwarded to the winner and the FSM stays in `IDLE`.
  - Otherwise `owner` is set to the winner and the FSM moves to `BUSY`.
- In `BUSY`:
  - Only the owner's signals are driven; the other master's request is ignored and its grant is held at 0.
  - When the memory grant arrives, it is forwarded to the owner and the FSM returns to `IDLE`.
  - If the owner drops its request (a protocol violation), the FSM returns to `IDLE` with no grant and nothing is driven.
- With no request asserted, all `mem_master` request, address, be and data fields are driven to 0.
- Read return path:
  - On a forwarded read grant, the grantee's id is registered in `ret_owner` and `ret_pend` is set.
  - In the next cycle, `mem_master.rd_data` is routed to `m<ret_owner>_rd_data` and `m<ret_owner>_rd_valid` pulses.
  - The other master's data output is 0.
- Back-to-back reads (grants in consecutive cycles) are supported; `ret_owner` updates every cycle.
- Simultaneous events:
  - A read and a write in the same cycle proceed independently on their own channels.
  - Both masters requesting in `IDLE` are resolved by the priority rule (see Configuration).
- Reset: both FSMs go to `IDLE`, `owner` = 0, `ret_pend` = 0, all grants, valids and data outputs = 0. Any in-flight transaction is dropped.

## Timing
- Request to memory: 0 cycles, combinational through the mux.
- Grant to master: same cycle as the memory grant; combinational from `mem_master.*_gnt` gated by owner/winner.
- Read data to master: exactly 1 cycle after `mx_rd_gnt`.
- Minimum grant latency per master: 0 cycles. No arbitration bubble after a grant.
- Handshake: a master must hold its req and fields stable from assertion through its grant cycle. A grant is never issued to a deasserted request.

## Configuration
- `RISCV_ARB_RR_EN` defined: round-robin arbitration.
  - A per-channel `last` bit records the most recent grantee.
  - On a tie in `IDLE`, the master that is not `last` wins.
  - `last` resets to 1, so master 0 wins the first tie.
- `RISCV_ARB_RR_EN` undefined: fixed priority; master 0 (data) always wins a tie. No `last` register exists.

## Structure
- Package `riscv_bus_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`
  - `typedef enum logic {OWN_DATA, OWN_FETCH} arb_owner_t`
  - localparam `BE_W = DATA_W/8`
- Sub-module `riscv_bus_arb_chan`:
  - One channel's FSM, winner selection, owner lock, grant gating, and the optional `last` bit.
  - Instantiated twice, once for rd and once for wr.
  - The read-return `ret_owner`/`ret_pend` registers live in the top level.

## Test plan
- Single read: m1 reads 0x100 with be 0xF; memory grants in the same cycle and returns 0xDEADBEEF next cycle -> `m1_rd_gnt` pulses in cycle 0; `m1_rd_valid` = 1 and `m1_rd_data` = 0xDEADBEEF in cycle 1; m0 outputs stay 0.
- Tie, fixed priority (macro off): m0 and m1 both read, memory grants every cycle -> m0 is granted first, m1 one cycle later, while m0 is still idle.
- Tie, round-robin (macro on): both masters hold reads for 4 grants -> grant order is m0, m1, m0, m1.
- Owner lock: m1 read stalled for 3 cycles while m0 raises a read in cycle 1 -> `mem_master.rd_addr` stays at m1's address; m1 is granted in cycle 3; m0 is granted in cycle 4.
- Concurrent channels: m0 writes 0x55 with be 0x1 to 0x200 while m1 reads 0x300 in the same cycle -> both are granted in the same cycle; `wr_data` = 0x55 at memory.
- Reset mid-op: `rst` is asserted while the read channel is in `BUSY` -> the next cycle has all grants/valids at 0 and both FSMs in `IDLE`; the dropped read returns no `rd_valid`.
